uart_tx_arb_ctrl: RTL



---
 rtl/uart_tx_arb_ctrl_pkg.sv | 15 +
 rtl/uart_tx_arb_ctrl_if.sv | 16 +
 rtl/uart_tx_arb_ctrl_baud_counter.sv | 29 ++
 rtl/uart_tx_arb_ctrl.sv | 131 +++++++++++++
 4 files changed

// File: rtl/uart_tx_arb_ctrl_pkg.sv
// Shared constants and state encoding for the UART transmit arbiter/controller.
package uart_tx_arb_ctrl_pkg;

  localparam int DATA_WIDTH_DEF   = 8;
  localparam int CLKS_PER_BIT_DEF = 16;

  typedef enum logic [2:0] {
    TX_IDLE   = 3'd0,
    TX_START  = 3'd1,
    TX_DATA   = 3'd2,
    TX_PARITY = 3'd3,
    TX_STOP   = 3'd4
  } tx_state_e;

endpackage

// File: rtl/uart_tx_arb_ctrl_if.sv
// Two-requester valid/ready bundle feeding the transmit arbiter.
interface uart_tx_arb_ctrl_if
  import uart_tx_arb_ctrl_pkg::*;
#(
  parameter int DATA_WIDTH = DATA_WIDTH_DEF
);

  logic [1:0]            req_valid;
  logic [DATA_WIDTH-1:0] req_data0;
  logic [DATA_WIDTH-1:0] req_data1;
  logic [1:0]            req_ready;

  modport master (output req_valid, req_data0, req_data1, input req_ready);
  modport slave  (input req_valid, req_data0, req_data1, output req_ready);

endinterface

// File: rtl/uart_tx_arb_ctrl_baud_counter.sv
// Per-bit cycle counter: wraps at CLKS_PER_BIT-1 and flags the last cycle of each bit.
module uart_baud_counter
  import uart_tx_arb_ctrl_pkg::*;
#(
  parameter int CLKS_PER_BIT = CLKS_PER_BIT_DEF
) (
  input  logic tx_clk,
  input  logic resetn,
  input  logic en,
  input  logic clr,
  output logic bit_end
);

  localparam int CNT_W = $clog2(CLKS_PER_BIT);
  localparam logic [CNT_W-1:0] LAST = CNT_W'(CLKS_PER_BIT - 1);

  logic [CNT_W-1:0] cnt;

  assign bit_end = en && (cnt == LAST);

  always_ff @(posedge tx_clk) begin
    if (!resetn || clr) begin
      cnt <= '0;
    end else if (en) begin
      cnt <= bit_end ? '0 : cnt + CNT_W'(1);
    end
  end

endmodule

// File: rtl/uart_tx_arb_ctrl.sv
// UART transmit controller: round-robin pick of two requesters, then start/data/parity/stop framing.
//   state     | meaning
//   TX_IDLE   | line high, req_ready offered to the arbitrated requester
//   TX_START  | start bit (tx=0)
//   TX_DATA   | payload bits, LSB first
//   TX_PARITY | parity of the latched word (only when PARITY_EN)
//   TX_STOP   | STOP_BITS stop bits (tx=1)
module uart_tx_arb_ctrl
  import uart_tx_arb_ctrl_pkg::*;
#(
  parameter int DATA_WIDTH   = DATA_WIDTH_DEF,
  parameter int CLKS_PER_BIT = CLKS_PER_BIT_DEF,
  parameter int PARITY_EN    = 1,
  parameter int PARITY_ODD   = 0,
  parameter int STOP_BITS    = 1
) (
  input  logic               tx_clk,
  input  logic               resetn,
  uart_tx_arb_ctrl_if.slave  req,
  output logic               tx,
  output logic               busy,
  output logic               done,
  output logic               done_id
);

  localparam int BIT_W = (DATA_WIDTH > 2) ? $clog2(DATA_WIDTH) : 1;
  localparam logic [BIT_W-1:0] LAST_DATA = BIT_W'(DATA_WIDTH - 1);
  localparam logic [BIT_W-1:0] LAST_STOP = BIT_W'(STOP_BITS - 1);

  tx_state_e             state, state_d;
  logic [DATA_WIDTH-1:0] shift_q, shift_d;
  logic [BIT_W-1:0]      bit_idx;
  logic                  parity_q;
  logic                  last_grant;
  logic                  frame_id;
  logic                  bit_end;
  logic                  accept;
  logic                  grant_id;
  logic [1:0]            ready;
  logic                  tx_d;
  logic                  frame_end;

  uart_baud_counter #(.CLKS_PER_BIT(CLKS_PER_BIT)) u_baud (
    .tx_clk  (tx_clk),
    .resetn  (resetn),
    .en      (busy),
    .clr     (accept),
    .bit_end (bit_end)
  );

  assign busy          = (state != TX_IDLE);
  assign req.req_ready = ready;
  assign accept        = |(req.req_valid & ready);
  assign frame_end     = (state == TX_STOP) && (state_d == TX_IDLE);

  always_ff @(posedge tx_clk) begin
    if (!resetn) state <= TX_IDLE;
    else         state <= state_d;
  end

  always_comb begin
    state_d = state;
    case (state)
      TX_IDLE:   if (accept) state_d = TX_START;
      TX_START:  if (bit_end) state_d = TX_DATA;
      TX_DATA:   if (bit_end && (bit_idx == LAST_DATA))
                   state_d = (PARITY_EN != 0) ? TX_PARITY : TX_STOP;
      TX_PARITY: if (bit_end) state_d = TX_STOP;
      TX_STOP:   if (bit_end && (bit_idx == LAST_STOP)) state_d = TX_IDLE;
      default:   state_d = TX_IDLE;
    endcase
  end

  // Both valid: the requester that did not win last time gets the slot.
  always_comb begin
    ready    = 2'b00;
    grant_id = 1'b0;
    if (state == TX_IDLE) begin
      case (req.req_valid)
        2'b01: begin ready = 2'b01; grant_id = 1'b0; end
        2'b10: begin ready = 2'b10; grant_id = 1'b1; end
        2'b11: begin
          grant_id = ~last_grant;
          ready    = last_grant ? 2'b01 : 2'b10;
        end
        default: ;
      endcase
    end
  end

  // tx is registered, so it is computed from the state being entered.
  always_comb begin
    shift_d = shift_q;
    if (accept)
      shift_d = grant_id ? req.req_data1 : req.req_data0;
    else if ((state == TX_DATA) && bit_end)
      shift_d = shift_q >> 1;
    case (state_d)
      TX_START:  tx_d = 1'b0;
      TX_DATA:   tx_d = shift_d[0];
      TX_PARITY: tx_d = parity_q;
      default:   tx_d = 1'b1;
    endcase
  end

  always_ff @(posedge tx_clk) begin
    if (!resetn) begin
      tx         <= 1'b1;
      done       <= 1'b0;
      done_id    <= 1'b0;
      shift_q    <= '0;
      parity_q   <= 1'b0;
      bit_idx    <= '0;
      last_grant <= 1'b1;
      frame_id   <= 1'b0;
    end else begin
      tx      <= tx_d;
      done    <= frame_end;
      shift_q <= shift_d;
      if (frame_end) done_id <= frame_id;
      if (accept) begin
        frame_id   <= grant_id;
        last_grant <= grant_id;
        parity_q   <= (^shift_d) ^ (PARITY_ODD != 0);
      end
      if (state_d != state) bit_idx <= '0;
      else if (bit_end)     bit_idx <= bit_idx + BIT_W'(1);
    end
  end

endmodule
